// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load, start/pause control and a one-cycle
// done pulse on reaching zero. Decrements only on tick while in RUN.
module bcd_digit (
  input  logic [3:0] cur,
  input  logic       borrow_in,
  input  logic [3:0] raw,
  output logic [3:0] dec,
  output logic       borrow_out,
  output logic [3:0] clamped
);
  assign borrow_out = borrow_in && (cur == 4'd0);
  assign clamped    = (raw > 4'd9) ? 4'd9 : raw;

  always_comb begin
    dec = cur;
    if (borrow_in) dec = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
  end
endmodule

module bcd_countdown_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   q,
  output logic                  running,
  output logic                  expired,
  output logic                  done
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t         state, state_n;
  logic [W-1:0]   q_n, q_dec, q_ld;
  logic [DIGITS:0] borrow;
  logic           done_n, q_zero;

  // The borrow ripples out of the top digit only when every digit is zero.
  assign borrow[0] = 1'b1;
  assign q_zero    = borrow[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .cur       (q[4*k +: 4]),
      .borrow_in (borrow[k]),
      .raw       (load_val[4*k +: 4]),
      .dec       (q_dec[4*k +: 4]),
      .borrow_out(borrow[k+1]),
      .clamped   (q_ld[4*k +: 4])
    );
  end

  always_comb begin
    q_n     = q;
    state_n = state;
    done_n  = 1'b0;
    if (load) begin
      q_n     = q_ld;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, PAUSED: if (!pause && start && !q_zero) state_n = RUN;
        RUN: begin
          if (pause) state_n = PAUSED;
          else if (tick) begin
            q_n = q_dec;
            // Decremented value of zero means q was 1: terminal count.
            if (q_dec == '0) begin
              state_n = EXPIRED;
              done_n  = 1'b1;
            end
          end
        end
        EXPIRED: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      q     <= q_n;
      state <= state_n;
      done  <= done_n;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);
endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Synchronous multi-digit BCD down-counter with load, start/pause control and an expiry flag. It is the count-down counterpart to the team's mod-10 up-counter. It serves as a countdown/timeout element in the same designs: software or a control FSM loads a decimal value, starts the timer, and receives a one-cycle `done` pulse when the count reaches zero. Counting advances only on a qualified `tick` strobe, so one fast clock can drive slow timebases.

## Interface
- `DIGITS`, default 2: number of BCD digits. Legal range is 1..8. The count width is 4*DIGITS.
- `clk`  in  1: sole clock. Everything is updated on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: load request, sampled at the rising edge.
- `load_val`  in  4*DIGITS: BCD value to load. Digit k occupies bits [4k+3:4k], and digit 0 is the least significant.
- `start`  in  1: begin or resume counting.
- `pause`  in  1: suspend counting.
- `tick`  in  1: count-enable strobe. One decrement per cycle in which `tick`=1 and the state is RUN.
- `q`  out  4*DIGITS: current BCD count, registered.
- `running`  out  1: 1 while the state is RUN.
- `expired`  out  1: level signal, 1 while the state is EXPIRED.
- `done`  out  1: one-cycle pulse on entry to EXPIRED.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Reset (`rst_n`=0), taking effect immediately and independent of `clk`:
  - `q`=0
  - state=IDLE
  - `running`=0, `expired`=0, `done`=0
- Priority per edge: `load` > `pause` > `start` > `tick`.
- `load`:
  - Valid in any state.
  - Sets `q` = `load_val`. Any digit greater than 9 is clamped to 9.
  - Forces state to IDLE. Any `start`/`tick` in the same cycle is ignored.
- `start`:
  - In IDLE or PAUSED with `q`≠0: go to RUN.
  - With `q`=0: ignored, state stays IDLE.
  - In RUN or EXPIRED: no effect.
- `pause`:
  - In RUN: go to PAUSED. A `tick` in the same cycle is dropped.
  - In other states: no effect.
- `tick` in RUN, BCD decrement:
  - Digit 0 decrements by one.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Non-zero digits never wrap.
- Terminal count: a `tick` in RUN with `q`=1 (all upper digits 0, digit 0 = 1) does the following:
  - `q` becomes 0.
  - State becomes EXPIRED.
  - `done`=1 for exactly that one following cycle.
- `q` never wraps below 0. Underflow is unreachable because RUN is never entered or held with `q`=0.
- EXPIRED:
  - `expired`=1, and `q` holds 0.
  - `start`, `pause` and `tick` are ignored.
  - Only `load` or reset leaves this state.
- `tick` in IDLE, PAUSED or EXPIRED: ignored, `q` holds.
- `running` and `expired` are decoded from the registered state, so they are glitch-free. `done` is a register cleared on every edge where no terminal count occurs.

## Timing
- Latency from any sampled control input to the updated `q`/`running`/`expired`/`done`: 1 clock edge. There is no combinational path from inputs to outputs.
- `start` at edge N: `running`=1 after edge N. The first decrement occurs on the first `tick` sampled at edge N+1 or later.
- Terminal tick sampled at edge N: after edge N, `q`=0, `expired`=1 and `done`=1. After edge N+1, `done`=0.
- Maximum decrement rate is one per clock (`tick` held high).
- Reset assertion mid-count clears all outputs without waiting for `clk`.
- Reset deassertion must be synchronous to `clk` at the system level. The first active edge after deassertion sees state=IDLE.

## Test plan
- Reset and load:
  - Assert `rst_n`=0 mid-RUN with `q`=37 → `q`=0, `running`=0 immediately.
  - Release reset, then load 8'h42 → `q`=8'h42, state IDLE, `running`=0.
- Borrow chain (`DIGITS`=2):
  - Load 8'h10, start, one tick → `q`=8'h09.
  - Next tick → `q`=8'h08.
  - Load 8'h00 → `start` ignored, `running` stays 0.
- Terminal count:
  - Load 8'h03, start, `tick` held high → `q` goes 02, 01, 00.
  - `done`=1 for exactly one cycle coincident with the first `q`=00 cycle.
  - `expired` stays 1.
  - Further ticks and `start` leave `q`=00.
- Pause/resume:
  - Load 8'h25, start, 3 ticks → `q`=8'h22.
  - `pause` together with `tick` → state PAUSED, `q`=8'h22.
  - 5 ticks while paused → no change.
  - `start`, 2 ticks → `q`=8'h20.
- Load priority and clamping:
  - In RUN, assert `load` with `load_val`=8'hFA plus `tick` and `pause` in the same cycle → `q`=8'h99, state IDLE, no decrement.
- Full span (`DIGITS`=2):
  - Load 8'h99, start, `tick` every third cycle → exactly 99 decrements.
  - Every intermediate `q` is valid BCD.
  - A single `done` pulse occurs at the 99th tick.
